// File: rtl/axis_frame_trailer.sv
// axis_frame_trailer: registered AXIS pass-through that appends an XOR-checksum trailer beat per frame
module axis_frame_trailer #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   input  logic                  bypass,
   output logic [CNT_WIDTH-1:0]  frame_beats,
   output logic                  frame_done,
   output logic                  cnt_sat
);
   typedef enum logic {PASS, TRAIL} state_t;
   state_t state_q, state_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d, csum_q, csum_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, beats_q, beats_d, cnt_inc;
   logic tvalid_q, tvalid_d, tlast_q, tlast_d, first_q, first_d, bp_q, bp_d;
   logic done_q, done_d, sat_q, sat_d;
   logic slot_free, s_hs, bp_eff, cnt_max;
   assign slot_free     = !tvalid_q || m_axis_tready;
   assign s_axis_tready = (state_q == PASS) && slot_free;
   assign s_hs          = s_axis_tvalid && s_axis_tready;
   assign bp_eff        = first_q ? bypass : bp_q;
   assign cnt_max       = &cnt_q;
   assign cnt_inc       = cnt_max ? cnt_q : cnt_q + CNT_WIDTH'(1);
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign frame_beats   = beats_q;
   assign frame_done    = done_q;
   assign cnt_sat       = sat_q;
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q  <= PASS;
         tdata_q  <= '0;
         csum_q   <= '0;
         cnt_q    <= '0;
         beats_q  <= '0;
         tvalid_q <= 1'b0;
         tlast_q  <= 1'b0;
         first_q  <= 1'b1;
         bp_q     <= 1'b0;
         done_q   <= 1'b0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tdata_q  <= tdata_d;
         csum_q   <= csum_d;
         cnt_q    <= cnt_d;
         beats_q  <= beats_d;
         tvalid_q <= tvalid_d;
         tlast_q  <= tlast_d;
         first_q  <= first_d;
         bp_q     <= bp_d;
         done_q   <= done_d;
         sat_q    <= sat_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      tdata_d  = tdata_q;
      csum_d   = csum_q;
      cnt_d    = cnt_q;
      beats_d  = beats_q;
      tvalid_d = slot_free ? 1'b0 : tvalid_q;
      tlast_d  = tlast_q;
      first_d  = first_q;
      bp_d     = bp_q;
      done_d   = 1'b0;
      sat_d    = sat_q;
      if (state_q == PASS) begin
         if (s_hs) begin
            tdata_d  = s_axis_tdata;
            tlast_d  = s_axis_tlast && bp_eff;
            tvalid_d = 1'b1;
            csum_d   = csum_q ^ s_axis_tdata;
            cnt_d    = cnt_inc;
            sat_d    = sat_q || cnt_max;
            first_d  = 1'b0;
            bp_d     = bp_eff;
            if (s_axis_tlast) begin
               beats_d = cnt_inc;
               // bypassed frames close here; others keep the checksum for the trailer
               if (bp_eff) begin
                  done_d  = 1'b1;
                  csum_d  = '0;
                  cnt_d   = '0;
                  first_d = 1'b1;
               end else begin
                  state_d = TRAIL;
               end
            end
         end
      end else if (slot_free) begin
         tdata_d  = csum_q;
         tlast_d  = 1'b1;
         tvalid_d = 1'b1;
         done_d   = 1'b1;
         csum_d   = '0;
         cnt_d    = '0;
         first_d  = 1'b1;
         state_d  = PASS;
      end
   end
endmodule

// File: tb/tb_axis_frame_trailer.sv
// tb_axis_frame_trailer: randomized/directed bench with a frame-level queue model of the trailer stream
module tb_axis_frame_trailer;
   localparam int DW = 32;
   localparam int CW = 3;
   localparam int MAXC = (1 << CW) - 1;
   typedef struct packed {logic [DW-1:0] d; logic l; logic b;} beat_t;
   logic aclk = 1'b0, aresetn = 1'b0;
   logic [DW-1:0] s_tdata = '0, m_tdata;
   logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, m_tvalid, m_tready = 1'b0, m_tlast, bypass = 1'b0;
   logic [CW-1:0] frame_beats;
   logic frame_done, cnt_sat;
   beat_t in_q[$];
   logic [DW:0] exp_q[$];
   int fb_q[$];
   int vectors = 0, errors = 0, acc = 0;
   logic [DW-1:0] m_csum = '0, pd = '0;
   int m_cnt = 0;
   bit m_first = 1, m_bp = 0, m_sat = 0, in_trail = 0;
   bit pv = 0, pr = 0, pl = 0, prst = 0;
   always #5 aclk = ~aclk;
   axis_frame_trailer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
      .bypass(bypass), .frame_beats(frame_beats), .frame_done(frame_done), .cnt_sat(cnt_sat)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic push_beat(input logic [DW-1:0] d, input logic l, input logic b);
      beat_t x;
      x.d = d; x.l = l; x.b = b;
      in_q.push_back(x);
   endtask
   // Frame-level model: every accepted beat is echoed; a non-bypassed frame adds its XOR as a final beat
   task automatic model_accept(input beat_t b);
      if (m_first) begin m_bp = b.b; m_first = 0; end
      m_csum ^= b.d;
      if (m_cnt == MAXC) m_sat = 1; else m_cnt++;
      exp_q.push_back({b.l && m_bp, b.d});
      if (b.l) begin
         fb_q.push_back(m_cnt);
         if (!m_bp) begin exp_q.push_back({1'b1, m_csum}); in_trail = 1; end
         m_csum = '0; m_cnt = 0; m_first = 1;
      end
   endtask
   task automatic tick();
      logic [DW:0] e;
      #1;
      if (aresetn) begin
         if (prst && pv && !pr) begin
            chk("stall_valid", m_tvalid, 1);
            chk("stall_data", m_tdata, pd);
            chk("stall_last", m_tlast, pl);
         end
         chk("cnt_sat", cnt_sat, m_sat);
         if (frame_done) begin
            chk("done_expected", fb_q.size() > 0, 1);
            if (fb_q.size() > 0) chk("frame_beats", frame_beats, fb_q.pop_front());
         end
         if (in_trail) begin
            chk("trail_tready", s_tready, 0);
            if (!m_tvalid || m_tready) in_trail = 0;
         end
         if (m_tvalid && m_tready) begin
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk("m_data", m_tdata, e[DW-1:0]);
               chk("m_last", m_tlast, e[DW]);
            end
         end
         if (s_tvalid && s_tready) begin
            model_accept(in_q.pop_front());
            acc++;
         end
      end else begin
         if (!prst) chk("rst_tvalid", m_tvalid, 0);
         exp_q.delete(); fb_q.delete();
         in_trail = 0; m_csum = '0; m_cnt = 0; m_first = 1; m_sat = 0;
      end
      pv = m_tvalid; pr = m_tready; pd = m_tdata; pl = m_tlast; prst = aresetn;
      @(posedge aclk);
      #1;
   endtask
   task automatic drive_front();
      if (in_q.size() > 0) begin
         s_tdata = in_q[0].d; s_tlast = in_q[0].l; bypass = in_q[0].b;
      end else begin
         s_tdata = $urandom; s_tlast = $urandom_range(0, 1); bypass = $urandom_range(0, 1);
      end
   endtask
   task automatic run(input int pct, input int budget);
      int n = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0 || in_trail || fb_q.size() > 0) && n < budget) begin
         s_tvalid = (in_q.size() > 0) && ($urandom_range(0, 3) != 0);
         drive_front();
         m_tready = $urandom_range(0, 99) < pct;
         tick();
         n++;
      end
      chk("run_in_budget", n < budget, 1);
      s_tvalid = 1'b0;
   endtask
   initial begin
      int len;
      bit bp;
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_frame_beats", frame_beats, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_cnt_sat", cnt_sat, 0);
      chk("rst_s_tready", s_tready, 1);
      aresetn = 1'b1;
      for (int i = 0; i < 4; i++) push_beat(DW'(1) << i, i == 3, 1'b0);
      run(100, 200);
      chk("t1_frame_beats", frame_beats, 4);
      push_beat(32'hDEADBEEF, 1'b1, 1'b0);
      run(100, 200);
      chk("t2_frame_beats", frame_beats, 1);
      for (int i = 0; i < 4; i++) push_beat(DW'(1) << i, i == 3, i == 0 || i == 2);
      run(100, 200);
      chk("t3_frame_beats", frame_beats, 4);
      for (int i = 0; i < 9; i++) push_beat($urandom, i == 8, 1'b0);
      run(70, 300);
      chk("sat_frame_beats", frame_beats, MAXC);
      chk("sat_flag", cnt_sat, 1);
      push_beat(32'h11, 1'b0, 1'b0);
      push_beat(32'h22, 1'b1, 1'b0);
      run(100, 200);
      chk("sat_next_beats", frame_beats, 2);
      chk("sat_sticky", cnt_sat, 1);
      for (int r = 0; r < 4; r++) begin
         for (int f = 0; f < 3; f++) begin
            len = $urandom_range(1, 6);
            bp = $urandom_range(0, 1);
            for (int i = 0; i < len; i++) push_beat($urandom, i == len - 1, i == 0 ? bp : 1'($urandom_range(0, 1)));
         end
         run(50, 600);
      end
      for (int i = 0; i < 4; i++) push_beat(DW'(i + 10), i == 3, 1'b0);
      acc = 0;
      for (int n = 0; n < 50 && acc < 2; n++) begin
         s_tvalid = 1'b1;
         drive_front();
         m_tready = 1'b1;
         tick();
      end
      chk("pre_reset_beats", acc, 2);
      aresetn = 1'b0;
      tick();
      tick();
      in_q.delete();
      aresetn = 1'b1;
      s_tvalid = 1'b0;
      push_beat(32'h3, 1'b0, 1'b0);
      push_beat(32'h5, 1'b1, 1'b0);
      run(100, 200);
      chk("post_reset_beats", frame_beats, 2);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
